// File: rtl/rv_pio_pkg.sv
// rv_pio_pkg: shared types, register offsets and byte-mask helper for rv_pio.
// Offsets are byte addresses within one channel window. Bits [1:0] of the
// bus address are ignored, so only offset bits [4:2] select a register.
package rv_pio_pkg;

    // Same layout as the rv_types.svh bus types; declared here so the block
    // elaborates on its own.
    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    localparam logic [4:0] PIO_OUT  = 5'h00;
    localparam logic [4:0] PIO_SET  = 5'h04;
    localparam logic [4:0] PIO_CLR  = 5'h08;
    localparam logic [4:0] PIO_TGL  = 5'h0C;
    localparam logic [4:0] PIO_IN   = 5'h10;
    localparam logic [4:0] PIO_IE   = 5'h14;
    localparam logic [4:0] PIO_IP   = 5'h18;
    localparam logic [4:0] PIO_EDGE = 5'h1C;

    localparam logic [7:0] PIO_STRIDE = 8'h20;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic u32_t byte_mask(input u4_t we);
        u32_t m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/rv_pio_ch.sv
// rv_pio_ch: one PIO channel -- OUT/IE/IP/EDGE registers, input synchroniser,
// edge detector and combinational read mux.
// Ports: clk/reset, wr (accepted write to this channel), ofs (register
// offset), wdat (byte-masked write data), wmask (byte mask), arm (edge events
// allowed), pin_in/pin_out, rdata (read mux), irq_ch (registered), irq_pend.
module rv_pio_ch
    import rv_pio_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [4:0]    ofs,
    input  logic [W-1:0]  wdat,
    input  logic [W-1:0]  wmask,
    input  logic          arm,
    input  logic [W-1:0]  pin_in,
    output logic [W-1:0]  pin_out,
    output logic [W-1:0]  rdata,
    output logic          irq_ch,
    output logic          irq_pend
);

    logic [W-1:0] out_q, ie_q, ip_q, edge_q;
    logic [W-1:0] sync1, sync2, prev;
    logic [W-1:0] ev, w1c, ip_nxt;

    // Per-bit edge select; events are held off while the top-level warm-up
    // counter runs so pins already high at reset do not latch IP.
    assign ev  = arm ? ((edge_q & sync2 & ~prev) | (~edge_q & ~sync2 & prev)) : '0;
    assign w1c = (wr && ofs == PIO_IP) ? wdat : '0;
    // A new event wins over a same-cycle write-1-to-clear of that bit.
    assign ip_nxt = (ip_q & ~w1c) | ev;

    assign irq_pend = |(ip_q & ie_q);
    assign pin_out  = out_q;

    always_comb begin
        rdata = '0;
        case (ofs)
            PIO_OUT:  rdata = out_q;
            PIO_IN:   rdata = sync2;
            PIO_IE:   rdata = ie_q;
            PIO_IP:   rdata = ip_q;
            PIO_EDGE: rdata = edge_q;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= RST_VAL;
            ie_q   <= '0;
            ip_q   <= '0;
            edge_q <= '1;
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            irq_ch <= 1'b0;
        end else begin
            sync1  <= pin_in;
            sync2  <= sync1;
            prev   <= sync2;
            ip_q   <= ip_nxt;
            irq_ch <= irq_pend;
            if (wr) begin
                case (ofs)
                    PIO_OUT:  out_q  <= (out_q  & ~wmask) | (wdat & wmask);
                    PIO_SET:  out_q  <= out_q | wdat;
                    PIO_CLR:  out_q  <= out_q & ~wdat;
                    PIO_TGL:  out_q  <= out_q ^ wdat;
                    PIO_IE:   ie_q   <= (ie_q   & ~wmask) | (wdat & wmask);
                    PIO_EDGE: edge_q <= (edge_q & ~wmask) | (wdat & wmask);
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: rtl/rv_pio.sv
// rv_pio: Nch-channel parallel I/O peripheral on the rv32 data bus.
// Ports: clk/reset, bus (adr, cs, rdy, we, re, dw, dr -- dr registered, zero
// when no read was accepted last cycle), pin_in/pin_out, irq_ch, irq.
// Channel select comes from adr[7:5]; windows at or beyond Nch are inert.
module rv_pio
    import rv_pio_pkg::*;
#(
    parameter int          Nch     = 4,
    parameter int          W       = 8,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       adr,
    input  logic             cs,
    input  logic             rdy,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [31:0]      dw,
    output logic [31:0]      dr,
    input  logic [Nch*W-1:0] pin_in,
    output logic [Nch*W-1:0] pin_out,
    output logic [Nch-1:0]   irq_ch,
    output logic             irq
);

    localparam logic [3:0] NCH4 = 4'(Nch);

    u32_t       m, d, rd_val;
    logic       wr_acc, rd_acc, in_rng;
    logic [2:0] ch_idx;
    logic [4:0] ofs;
    logic [1:0] warm;
    logic       arm;

    logic [W-1:0]   ch_rd [Nch];
    logic [Nch-1:0] ch_pend;

    // adr[1:0] and the unused upper write-data bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{adr[1:0], d, m};

    assign m      = byte_mask(we);
    assign d      = dw & m;
    assign wr_acc = cs & rdy & (|we);
    assign rd_acc = cs & rdy & re;
    assign ch_idx = adr[7:5];
    assign ofs    = {adr[4:2], 2'b00};
    assign in_rng = ({1'b0, ch_idx} < NCH4);
    assign arm    = (warm == 2'd3);

    for (genvar c = 0; c < Nch; c++) begin : g_ch
        rv_pio_ch #(
            .W       (W),
            .RST_VAL (OUT_RST[W-1:0])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr_acc && in_rng && (ch_idx == 3'(c))),
            .ofs      (ofs),
            .wdat     (d[W-1:0]),
            .wmask    (m[W-1:0]),
            .arm      (arm),
            .pin_in   (pin_in[c*W +: W]),
            .pin_out  (pin_out[c*W +: W]),
            .rdata    (ch_rd[c]),
            .irq_ch   (irq_ch[c]),
            .irq_pend (ch_pend[c])
        );
    end

    // OR-reduce the selected channel's read value; out-of-range reads give 0.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < Nch; c++) begin
            if (in_rng && ch_idx == 3'(c)) begin
                rd_val[W-1:0] = rd_val[W-1:0] | ch_rd[c];
            end
        end
    end

    // irq is registered from the same pending terms as irq_ch so both
    // assert on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr   <= '0;
            irq  <= 1'b0;
            warm <= 2'd0;
        end else begin
            dr   <= rd_acc ? rd_val : 32'h0;
            irq  <= |ch_pend;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv_pio.sv
module tb_rv_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  adr = '0;
    logic        cs = 1'b0;
    logic        rdy = 1'b1;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] dw = '0;
    logic [31:0] dr;
    logic [31:0] pin_in = '0;
    logic [31:0] pin_out;
    logic [3:0]  irq_ch;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    rv_pio #(.Nch(4), .W(8), .OUT_RST(32'h5A)) dut (
        .clk     (clk),
        .reset   (reset),
        .adr     (adr),
        .cs      (cs),
        .rdy     (rdy),
        .we      (we),
        .re      (re),
        .dw      (dw),
        .dr      (dr),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .irq_ch  (irq_ch),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle. If r is set the expected read value goes on the
    // scoreboard and is popped against dr once the accepting edge has passed.
    task automatic access(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w,
                          input logic r, input logic [31:0] rexp, input string tag);
        @(negedge clk);
        adr = a; dw = d; we = w; re = r; cs = 1'b1;
        if (r && rdy) exp_q.push_back(rexp);
        @(posedge clk);
        #1;
        cs = 1'b0; we = '0; re = 1'b0;
        if (r && rdy) begin
            if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
            else check(tag, dr, exp_q.pop_front());
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        access(a, d, w, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
        access(a, 32'h0, 4'h0, 1'b1, e, tag);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        cycles(3);
        @(negedge clk); reset = 1'b0;
        #1;
        check("rst_pin_out", pin_out, 32'h5A5A5A5A);
        check("rst_dr", dr, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_irq_ch", {28'h0, irq_ch}, 32'h0);

        // OUT write to channel 1, then read back for exactly one cycle
        wr(8'h20, 32'h000000C3, 4'b0001);
        check("out_wr", pin_out, 32'h5A5AC35A);
        rd(8'h20, 32'h000000C3, "out_rd");
        cycles(1);
        check("dr_one_cycle", dr, 32'h0);

        // Write modes and byte masking on channel 1
        wr(8'h20, 32'h000000F0, 4'b0001);
        check("out_f0", pin_out[15:8], 32'hF0);
        wr(8'h24, 32'h0000000F, 4'b0001);
        check("set", pin_out[15:8], 32'hFF);
        wr(8'h28, 32'h00000081, 4'b0001);
        check("clr", pin_out[15:8], 32'h7E);
        wr(8'h2C, 32'h000000FF, 4'b0001);
        check("tgl", pin_out[15:8], 32'h81);
        access(8'h2C, 32'h000000FF, 4'b0000, 1'b0, 32'h0, "tgl_nowe");
        check("tgl_masked", pin_out[15:8], 32'h81);
        wr(8'h20, 32'h0000AA55, 4'b0010);
        check("out_byte_mask", pin_out[15:8], 32'h81);
        rd(8'h24, 32'h0, "set_reads_0");

        // Rising-edge interrupt on channel 2 bit 0
        wr(8'h54, 32'h01, 4'b0001);
        wr(8'h5C, 32'h01, 4'b0001);
        @(negedge clk); pin_in[16] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("irq_early", {31'h0, irq}, 32'h0);
        end
        @(posedge clk); #1;
        check("irq_edge4", {31'h0, irq}, 32'h1);
        check("irq_ch_edge4", {28'h0, irq_ch}, 32'h4);
        rd(8'h58, 32'h01, "ip_ch2");
        rd(8'h50, 32'h01, "in_ch2");
        wr(8'h58, 32'h01, 4'b0001);
        check("irq_hold_after_w1c", {31'h0, irq}, 32'h1);
        cycles(1);
        check("irq_drop", {31'h0, irq}, 32'h0);
        rd(8'h58, 32'h00, "ip_ch2_cleared");

        // Falling edge on ch0 bit 3 coinciding with W1C of that bit
        wr(8'h1C, 32'h00, 4'b0001);
        @(negedge clk); pin_in[3] = 1'b1;
        cycles(5);
        rd(8'h18, 32'h00, "ip_no_rise_event");
        @(negedge clk); pin_in[3] = 1'b0;    // before edge k
        @(posedge clk);                       // k
        @(posedge clk);                       // k+1
        wr(8'h18, 32'h08, 4'b0001);           // accepted at k+2
        rd(8'h18, 32'h08, "ip_set_priority");
        wr(8'h18, 32'h08, 4'b0001);
        rd(8'h18, 32'h00, "ip_w1c");

        // Warm-up: inputs high through reset release
        @(negedge clk); reset = 1'b1; pin_in = '1;
        cycles(2);
        @(negedge clk); reset = 1'b0;
        cycles(8);
        for (int c = 0; c < 4; c++) begin
            rd(8'(c * 32 + 8'h18), 32'h0, "ip_warmup");
        end
        check("irq_warmup", {31'h0, irq}, 32'h0);
        rd(8'h10, 32'hFF, "in_all_ones");

        // Out of range
        wr(8'h80, 32'hFFFFFFFF, 4'b1111);
        wr(8'h8C, 32'hFFFFFFFF, 4'b1111);
        check("range_wr", pin_out, 32'h5A5A5A5A);
        rd(8'h80, 32'h0, "range_rd");

        // Stall: no bus effects while rdy=0
        rdy = 1'b0;
        access(8'h00, 32'h11, 4'b0001, 1'b1, 32'h0, "stall");
        check("stall_out", pin_out, 32'h5A5A5A5A);
        check("stall_dr", dr, 32'h0);
        rdy = 1'b1;

        // Simultaneous write and read returns the pre-write value
        access(8'h00, 32'h33, 4'b0001, 1'b1, 32'h5A, "rd_prewrite");
        check("wr_with_rd", pin_out, 32'h5A5A5A33);

        // Raise irq via a falling edge on ch0 bit 0, then reset during a write
        wr(8'h1C, 32'h00, 4'b0001);
        wr(8'h14, 32'h01, 4'b0001);
        @(negedge clk); pin_in[0] = 1'b0;
        cycles(5);
        check("irq_fall", {31'h0, irq}, 32'h1);
        @(negedge clk);
        adr = 8'h00; dw = 32'h77; we = 4'b0001; cs = 1'b1;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_out", pin_out, 32'h5A5A5A5A);
        check("rst_abort_irq", {31'h0, irq}, 32'h0);
        check("rst_abort_dr", dr, 32'h0);
        cs = 1'b0; we = '0;
        @(negedge clk); reset = 1'b0;
        cycles(2);
        check("rst_abort_out_after", pin_out, 32'h5A5A5A5A);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
